life_gen_engine: RTL and testbench
==================================

// Module: life_gen_engine
// PURPOSE
//  Consumer of the evolve tick (envolve_v) produced by the speed controller.
//  Holds the Game-of-Life grid and computes one new generation per accepted tick.
//  Works one row per cycle on a toroidal grid and commits the result atomically.
//  Provides a cell-edit port for seeding and a registered row-read port for VGA.
// PARAMETERS
//  W      16  grid width in cells (bits per row), 3..32
//  H      16  grid height in rows, 3..32
//  GEN_W  16  width of generation counter
// PORTS
//  clk        in   1                clock
//  rst        in   1                async reset, active-high
//  run_en     in   1                1 = ticks accepted; 0 = ticks ignored (edit mode)
//  envolve_v  in   1                one-cycle evolve tick
//  clr        in   1                sync clear of grid, gen_cnt, overrun
//  edit_we    in   1                cell write strobe
//  edit_x     in   $clog2(W)        cell column
//  edit_y     in   $clog2(H)        cell row
//  edit_val   in   1                value written (1 = alive)
//  disp_y     in   $clog2(H)        display row select
//  disp_row   out  W                cur-grid row disp_y, registered; bit x = column x
//  busy       out  1                high while not IDLE
//  done       out  1                one-cycle pulse on commit
//  gen_cnt    out  GEN_W            committed generations, wraps at 2^GEN_W
//  overrun    out  1                sticky: tick arrived while busy
// BEHAVIOUR
//  - Reset: cur grid, nxt grid all 0; state IDLE; disp_row=0, busy=0, done=0,
//    gen_cnt=0, overrun=0. Async assert, sync-safe release.
//  - States: IDLE -> COMPUTE -> COMMIT -> IDLE.
//  - IDLE: if clr: clear cur, gen_cnt, overrun; tick and edit in same cycle dropped.
//    Else if envolve_v & run_en: row<=0, go COMPUTE; same-cycle edit dropped.
//    Else if edit_we: cur[edit_y][edit_x]<=edit_val (visible on disp_row after 2 edges).
//  - COMPUTE: each cycle nxt[row] <= rule(cur[row-1], cur[row], cur[row+1]);
//    row and column indices wrap mod H / mod W (torus). After row H-1 -> COMMIT.
//  - Rule: alive' = (n==3) | (alive & n==2), n = 8-neighbour count (4-bit).
//  - COMMIT: cur<=nxt, gen_cnt<=gen_cnt+1, done=1 for this cycle only, -> IDLE.
//  - Latency: tick sampled at edge 0; nxt rows written edges 1..H; commit at
//    edge H+1 (done high following that edge); busy high edges 0..H+1 window,
//    next tick accepted at edge H+2. Throughput 1 gen / H+2 cycles.
//  - Tick while busy: ignored, overrun<=1 (sticky until clr or rst).
//  - clr/edit_we while busy: ignored (no queuing); cur is untouched until COMMIT.
//  - run_en low: ticks ignored silently, overrun unaffected.
//  - disp_row <= cur[disp_y] every cycle incl. busy; shows last committed gen.
//  - Reset mid-COMPUTE: grid lost, returns to reset state; no done pulse.
// TESTING
//  1 Blinker: edit (6,7),(7,7),(8,7)=1; tick -> after done rows 6,7,8 = 0x0080,
//    gen_cnt=1; 2nd tick -> row7=0x01C0, rows 6,8=0.
//  2 Torus wrap: set row0 cols 15,0,1 (0x8003); tick -> rows 15,0,1 = 0x0001,
//    all other rows 0.
//  3 Latency: tick at edge T -> busy high after T, done pulse exactly after edge
//    T+17 (H=16), busy low same edge; second tick at T+5 -> overrun=1, gen_cnt=1.
//  4 Edit/clr during busy ignored; clr+tick same cycle in IDLE -> grid 0,
//    gen_cnt=0, busy stays 0.
//  5 run_en=0 with ticks every 40 cycles -> gen_cnt stays 0, overrun 0.
//  6 rst pulse mid-COMPUTE -> all outputs 0 immediately, grid empty, no done.

Source files
------------

// File: rtl/life_gen_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : life_gen_engine                                                  |
// | Purpose : Toroidal Game-of-Life grid, one row per cycle, atomic commit,    |
// |           with a cell-edit port and a registered display row port.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module life_gen_engine #(
  parameter int W     = 16,
  parameter int H     = 16,
  parameter int GEN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_en,
  input  logic                  envolve_v,
  input  logic                  clr,
  input  logic                  edit_we,
  input  logic [$clog2(W)-1:0]  edit_x,
  input  logic [$clog2(H)-1:0]  edit_y,
  input  logic                  edit_val,
  input  logic [$clog2(H)-1:0]  disp_y,
  output logic [W-1:0]          disp_row,
  output logic                  busy,
  output logic                  done,
  output logic [GEN_W-1:0]      gen_cnt,
  output logic                  overrun
);

  localparam int              c_YW   = $clog2(H);
  localparam logic [c_YW-1:0] c_LAST = c_YW'(H - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_YW-1:0]   r_row;
  logic [W-1:0]      r_cur [H];
  logic [W-1:0]      r_nxt [H];
  logic [W-1:0]      r_disp_row;
  logic              r_busy;
  logic              r_done;
  logic [GEN_W-1:0]  r_gen;
  logic              r_overrun;

  logic [c_YW-1:0]   w_row_up;
  logic [c_YW-1:0]   w_row_dn;
  logic [W-1:0]      w_up;
  logic [W-1:0]      w_mid;
  logic [W-1:0]      w_dn;
  logic [W-1:0]      w_rule;
  logic              w_tick;

  assign w_tick   = envolve_v & run_en;
  assign w_row_up = (r_row == '0)     ? c_LAST : r_row - c_YW'(1);
  assign w_row_dn = (r_row == c_LAST) ? '0     : r_row + c_YW'(1);
  assign w_up     = r_cur[w_row_up];
  assign w_mid    = r_cur[r_row];
  assign w_dn     = r_cur[w_row_dn];

  // One rule evaluator per column; left/right neighbours wrap around the torus.
  for (genvar x = 0; x < W; x++) begin : g_col
    localparam int c_XL = (x == 0)     ? W - 1 : x - 1;
    localparam int c_XR = (x == W - 1) ? 0     : x + 1;
    logic [3:0] w_n;
    assign w_n = {3'b0, w_up[c_XL]}  + {3'b0, w_up[x]}  + {3'b0, w_up[c_XR]}
               + {3'b0, w_mid[c_XL]}                    + {3'b0, w_mid[c_XR]}
               + {3'b0, w_dn[c_XL]}  + {3'b0, w_dn[x]}  + {3'b0, w_dn[c_XR]};
    assign w_rule[x] = (w_n == 4'd3) | (w_mid[x] & (w_n == 4'd2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_cur      <= '{default: '0};
      r_nxt      <= '{default: '0};
      r_disp_row <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_gen      <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_disp_row <= r_cur[disp_y];
      case (r_state)
        S_IDLE: begin
          if (clr) begin
            r_cur     <= '{default: '0};
            r_gen     <= '0;
            r_overrun <= 1'b0;
          end else if (w_tick) begin
            r_row   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_COMPUTE;
          end else if (edit_we) begin
            r_cur[edit_y][edit_x] <= edit_val;
          end
        end
        S_COMPUTE: begin
          r_nxt[r_row] <= w_rule;
          if (w_tick) r_overrun <= 1'b1;
          if (r_row == c_LAST) r_state <= S_COMMIT;
          else                 r_row   <= r_row + c_YW'(1);
        end
        S_COMMIT: begin
          r_cur   <= r_nxt;
          r_gen   <= r_gen + GEN_W'(1);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (w_tick) r_overrun <= 1'b1;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign disp_row = r_disp_row;
  assign busy     = r_busy;
  assign done     = r_done;
  assign gen_cnt  = r_gen;
  assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_life_gen_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_life_gen_engine                                               |
// | Purpose : Scoreboard bench for life_gen_engine against an array model.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_life_gen_engine;
  localparam int W     = 16;
  localparam int H     = 16;
  localparam int GEN_W = 16;
  localparam int XW    = $clog2(W);
  localparam int YW    = $clog2(H);

  typedef logic [H-1:0][W-1:0] grid_t;
  typedef struct packed {
    logic             snap;
    logic [GEN_W-1:0] gen;
    grid_t            grid;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run_en = 1'b0;
  logic             envolve_v = 1'b0;
  logic             clr = 1'b0;
  logic             edit_we = 1'b0;
  logic             edit_val = 1'b0;
  logic [XW-1:0]    edit_x = '0;
  logic [YW-1:0]    edit_y = '0;
  logic [YW-1:0]    disp_y = '0;
  logic [W-1:0]     disp_row;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen_cnt;
  logic             overrun;

  int               n_tests = 0;
  int               n_fail  = 0;
  int               pushed  = 0;
  int               handled = 0;
  exp_t             exp_q[$];
  grid_t            mdl = '0;
  logic [GEN_W-1:0] mgen = '0;

  life_gen_engine #(.W(W), .H(H), .GEN_W(GEN_W)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .envolve_v(envolve_v), .clr(clr),
    .edit_we(edit_we), .edit_x(edit_x), .edit_y(edit_y), .edit_val(edit_val),
    .disp_y(disp_y), .disp_row(disp_row), .busy(busy), .done(done),
    .gen_cnt(gen_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: count the 8 torus neighbours of every cell directly.
  function automatic grid_t life_step(input grid_t g);
    grid_t r = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0)
              n += int'(g[(y + dy + H) % H][(x + dx + W) % W]);
        r[y][x] = (n == 3) || (g[y][x] && n == 2);
      end
    return r;
  endfunction

  function automatic void push_tick(input grid_t g);
    exp_t e;
    mgen   = mgen + 1'b1;
    mdl    = g;
    e.snap = 1'b0;
    e.gen  = mgen;
    e.grid = g;
    exp_q.push_back(e);
    pushed++;
  endfunction

  function automatic void push_snap();
    exp_t e;
    e.snap = 1'b1;
    e.gen  = mgen;
    e.grid = mdl;
    exp_q.push_back(e);
    pushed++;
  endfunction

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic wait_handled();
    int t = 0;
    while (handled != pushed && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (handled != pushed) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_timeout: handled %0d of %0d expected items", handled, pushed);
      finish_run();
    end
  endtask

  task automatic edit_cell(input int x, input int y, input logic v);
    edit_x   = XW'(x);
    edit_y   = YW'(y);
    edit_val = v;
    edit_we  = 1'b1;
    @(negedge clk);
    edit_we  = 1'b0;
    if (v) mdl[y][x] = 1'b1;
    else   mdl[y][x] = 1'b0;
  endtask

  task automatic tick();
    envolve_v = 1'b1;
    @(negedge clk);
    envolve_v = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr  = 1'b0;
    mdl  = '0;
    mgen = '0;
  endtask

  task automatic sweep(input grid_t g);
    for (int y = 0; y < H; y++) begin
      disp_y = YW'(y);
      @(negedge clk);
      check($sformatf("disp_row%0d", y), disp_row, g[y]);
    end
  endtask

  // Monitor: pops one expected item per done pulse or per idle snapshot.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].snap) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_unexpected: got done=1, expected no commit");
        end else begin
          e = exp_q.pop_front();
          check("gen_at_done", gen_cnt, e.gen);
          check("busy_at_done", busy, 0);
          sweep(e.grid);
          handled++;
        end
      end else if (exp_q.size() > 0 && exp_q[0].snap && busy === 1'b0) begin
        e = exp_q.pop_front();
        check("gen_snapshot", gen_cnt, e.gen);
        sweep(e.grid);
        handled++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    grid_t g;
    int    early_done;
    int    busy_low;
    int    busy_seen;

    // Reset state
    @(negedge clk);
    check("rst_disp_row", disp_row, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_gen", gen_cnt, 0);
    check("rst_overrun", overrun, 0);
    rst    = 1'b0;
    run_en = 1'b1;
    push_snap();
    wait_handled();

    // Blinker
    edit_cell(6, 7, 1'b1);
    edit_cell(7, 7, 1'b1);
    edit_cell(8, 7, 1'b1);
    g = '0; g[7] = 16'h01C0;
    push_snap();
    wait_handled();
    g = '0; g[6] = 16'h0080; g[7] = 16'h0080; g[8] = 16'h0080;
    push_tick(g);
    tick();
    wait_handled();
    g = '0; g[7] = 16'h01C0;
    push_tick(g);
    tick();
    wait_handled();

    // Torus wrap
    do_clr();
    edit_cell(15, 0, 1'b1);
    edit_cell(0, 0, 1'b1);
    edit_cell(1, 0, 1'b1);
    g = '0; g[15] = 16'h0001; g[0] = 16'h0001; g[1] = 16'h0001;
    push_tick(g);
    tick();
    wait_handled();

    // Latency and overrun
    do_clr();
    edit_cell(6, 7, 1'b1);
    edit_cell(7, 7, 1'b1);
    edit_cell(8, 7, 1'b1);
    push_tick(life_step(mdl));
    envolve_v = 1'b1;
    @(negedge clk);
    envolve_v = 1'b0;
    check("lat_busy_after_tick", busy, 1);
    early_done = 0;
    busy_low   = 0;
    for (int k = 1; k <= H + 1; k++) begin
      if (k == 5) envolve_v = 1'b1;
      @(negedge clk);
      envolve_v = 1'b0;
      if (k <= H) begin
        if (done !== 1'b0) early_done++;
        if (busy !== 1'b1) busy_low++;
      end
    end
    check("lat_early_done_cycles", early_done, 0);
    check("lat_busy_gaps", busy_low, 0);
    check("lat_done_at_T17", done, 1);
    check("lat_busy_low_at_T17", busy, 0);
    @(negedge clk);
    check("lat_done_one_cycle", done, 0);
    wait_handled();
    check("lat_overrun", overrun, 1);
    check("lat_gen", gen_cnt, 1);

    // Edit and clr while busy are ignored
    push_tick(life_step(mdl));
    tick();
    edit_x = '0; edit_y = '0; edit_val = 1'b1; edit_we = 1'b1;
    @(negedge clk);
    edit_we = 1'b0;
    clr     = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wait_handled();
    check("busy_clr_overrun_kept", overrun, 1);

    // clr + tick + edit in the same idle cycle
    clr = 1'b1; envolve_v = 1'b1;
    edit_x = 4'd3; edit_y = 4'd3; edit_val = 1'b1; edit_we = 1'b1;
    @(negedge clk);
    clr = 1'b0; envolve_v = 1'b0; edit_we = 1'b0;
    mdl = '0; mgen = '0;
    busy_seen = int'(busy);
    repeat (4) begin
      @(negedge clk);
      busy_seen += int'(busy);
    end
    check("clr_tick_busy", busy_seen, 0);
    check("clr_tick_gen", gen_cnt, 0);
    check("clr_tick_overrun", overrun, 0);
    push_snap();
    wait_handled();

    // run_en low: ticks ignored silently
    run_en = 1'b0;
    edit_cell(4, 4, 1'b1);
    edit_cell(5, 4, 1'b1);
    edit_cell(6, 4, 1'b1);
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      busy_seen += int'(busy);
      repeat (39) begin
        @(negedge clk);
        busy_seen += int'(busy);
      end
    end
    check("runen_busy", busy_seen, 0);
    check("runen_gen", gen_cnt, 0);
    check("runen_overrun", overrun, 0);
    push_snap();
    wait_handled();
    run_en = 1'b1;

    // Randomized seeding and generations
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 30; k++)
        edit_cell(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
                  logic'($urandom_range(0, 1)));
      push_snap();
      wait_handled();
      for (int n = 0; n < 3; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push_tick(life_step(mdl));
        tick();
        wait_handled();
      end
    end

    // Reset mid-COMPUTE
    edit_cell(2, 2, 1'b1);
    edit_cell(3, 2, 1'b1);
    edit_cell(4, 2, 1'b1);
    tick();
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_disp_row", disp_row, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_gen", gen_cnt, 0);
    check("midrst_overrun", overrun, 0);
    @(negedge clk);
    rst  = 1'b0;
    mdl  = '0;
    mgen = '0;
    push_snap();
    wait_handled();
    repeat (30) @(negedge clk);
    check("midrst_busy_after", busy, 0);
    check("queue_drained", exp_q.size(), 0);

    finish_run();
  end

endmodule
`default_nettype wire
